counter_monitor: RTL

- Synthesizable checker that sits on the output side of the 4-bit mode counter.
- Snoops the same `clk`/`reset`/`enable`/`mode`/`D` the counter sees and runs its own cycle-accurate model.
- Compares the model against the counter's registered `Q`/`rco`/`load` every cycle; reports mismatches as a pulse, a sticky flag and a saturating count.
- Consumes the counter interface where the driver produces it; instantiated beside the counter in benches and as an on-chip self-check.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_model.sv | 53 +++++
 rtl/counter_monitor.sv | 84 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the 4-bit mode counter and its checkers:
// mode encodings, monitor FSM state encodings and the default data width.
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH = 4;

    localparam logic [1:0] MODE_UP3  = 2'b00;
    localparam logic [1:0] MODE_DN1  = 2'b01;
    localparam logic [1:0] MODE_UP1  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_TRACK  = 2'b01;
    localparam logic [1:0] ST_RESYNC = 2'b10;

endpackage

// File: rtl/counter_model.sv
// Combinational next-value function of the mode counter: given the old count
// and the controls, returns the next {Q, rco, load}.
module counter_model
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH
) (
    input  logic [WIDTH-1:0] old_Q,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] nQ,
    output logic             nrco,
    output logic             nload
);

    localparam logic [WIDTH:0] STEP1 = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP3 = (WIDTH+1)'(3);

    // Carry/borrow land in the extra top bit of the widened intermediate.
    logic [WIDTH:0] sum;

    always_comb begin
        sum   = '0;
        nQ    = old_Q;
        nrco  = 1'b0;
        nload = 1'b0;
        if (enable) begin
            case (mode)
                MODE_UP3: begin
                    sum  = {1'b0, old_Q} + STEP3;
                    nQ   = sum[WIDTH-1:0];
                    nrco = sum[WIDTH];
                end
                MODE_DN1: begin
                    sum  = {1'b0, old_Q} - STEP1;
                    nQ   = sum[WIDTH-1:0];
                    nrco = sum[WIDTH];
                end
                MODE_UP1: begin
                    sum  = {1'b0, old_Q} + STEP1;
                    nQ   = sum[WIDTH-1:0];
                    nrco = sum[WIDTH];
                end
                default: begin
                    nQ    = D;
                    nload = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_monitor.sv
// Cycle-accurate checker for the mode counter: tracks a private model and flags
// Q/rco/load mismatches. Optional realignment after a mismatch: COUNTER_MONITOR_RESYNC_EN.
module counter_monitor
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic             rco,
    input  logic             load,
    output logic             tracking,
    output logic [WIDTH-1:0] exp_Q,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
);

    logic [1:0]       state;
    logic             exp_rco;
    logic             exp_load;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] n_q;
    logic             n_rco;
    logic             n_load;
    logic             mismatch;

    assign tracking = (state == ST_TRACK);

    always_comb begin
        base_q = exp_Q;
`ifdef COUNTER_MONITOR_RESYNC_EN
        // Realign to what the counter actually shows after a reported fault.
        if (state == ST_RESYNC) base_q = Q;
`endif
        mismatch = (state == ST_TRACK) &&
                   ({Q, rco, load} != {exp_Q, exp_rco, exp_load});
    end

    counter_model #(.WIDTH(WIDTH)) u_model (
        .old_Q  (base_q),
        .enable (enable),
        .mode   (mode),
        .D      (D),
        .nQ     (n_q),
        .nrco   (n_rco),
        .nload  (n_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            exp_Q      <= '0;
            exp_rco    <= 1'b0;
            exp_load   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            exp_Q    <= n_q;
            exp_rco  <= n_rco;
            exp_load <= n_load;
            err      <= mismatch;
            if (mismatch) err_sticky <= 1'b1;
            if (mismatch && (err_count != '1)) err_count <= err_count + ERR_W'(1);
            case (state)
                ST_IDLE:   state <= ST_TRACK;
                ST_TRACK: begin
`ifdef COUNTER_MONITOR_RESYNC_EN
                    if (mismatch) state <= ST_RESYNC;
`endif
                end
                ST_RESYNC: state <= ST_TRACK;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
